sram_read_ctrl: RTL
===================

// Module: sram_read_ctrl
// PURPOSE
//  SRAM-side responder for the background loader's read handshake. Accepts a word
//  read request (reading + ADDR) and drives the external 16-bit async SRAM pins
//  with configurable wait states. It latches the read word and pulses SRAM_done
//  once DATA_OUT is valid. Sits between the background loader and the board SRAM.
//  Read-only: SRAM_WE_N is held high at all times.
// PARAMETERS
//  ADDR_W       20  word address width (SRAM word-addressed, 16 bits/word)
//  WAIT_CYCLES  2   extra cycles between address/OE assertion and data capture; 0..15
// PORTS
//  Clk          in   1       system clock
//  Reset        in   1       asynchronous, active-high reset
//  reading      in   1       read request level from the loader
//  ADDR         in   ADDR_W  word address; sampled only when a request is accepted
//  SRAM_DQ      in   16      SRAM data bus (input only in this block)
//  SRAM_ADDR    out  ADDR_W  SRAM address pins
//  SRAM_CE_N    out  1       chip enable, active low
//  SRAM_OE_N    out  1       output enable, active low
//  SRAM_WE_N    out  1       write enable, constant 1
//  SRAM_UB_N    out  1       upper byte enable, active low
//  SRAM_LB_N    out  1       lower byte enable, active low
//  DATA_OUT     out  16      last captured word; holds until the next capture
//  SRAM_done    out  1       one-cycle pulse: DATA_OUT is valid for the current request
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values:
//      state = IDLE; SRAM_ADDR = 0; DATA_OUT = 0; SRAM_done = 0; wait counter = 0
//      SRAM_CE_N = SRAM_OE_N = SRAM_UB_N = SRAM_LB_N = 1; SRAM_WE_N = 1
//  - FSM states: IDLE, SETUP, WAIT, CAPTURE, DONE, HOLD.
//  - IDLE: if reading = 1 at a clock edge, latch ADDR into SRAM_ADDR and go to SETUP.
//      Otherwise stay in IDLE.
//  - SETUP: CE_N, OE_N, UB_N and LB_N are driven to 0 (registered, so low from SETUP on).
//      Next state is WAIT with the counter loaded to WAIT_CYCLES-1.
//      If WAIT_CYCLES = 0, next state is CAPTURE.
//  - WAIT: counter decrements each cycle; go to CAPTURE when the counter reaches 0.
//      Exactly WAIT_CYCLES cycles are spent in WAIT.
//  - CAPTURE: DATA_OUT <= SRAM_DQ at the end of this cycle. Enables remain low
//      through CAPTURE and return to 1 on entry to DONE.
//  - DONE: SRAM_done = 1 for exactly this one cycle. Next state is HOLD if
//      reading = 1, else IDLE.
//  - HOLD: wait until reading = 0, then go to IDLE. A request held high after DONE
//      never causes a second read; reading must drop for at least 1 cycle between requests.
//  - Latency: reading sampled high in IDLE at edge N gives SRAM_done = 1 during cycle
//      N+3+WAIT_CYCLES. With the default (2), SRAM_done is high in cycle N+5.
//  - Abort: reading = 0 in SETUP, WAIT or CAPTURE returns the FSM to IDLE next cycle.
//      Enables deassert, no SRAM_done is issued, and DATA_OUT keeps its prior value.
//  - ADDR changes after acceptance are ignored until the next IDLE acceptance.
//  - Reset asserted mid-transaction: immediate (asynchronous) return to the reset values;
//      no SRAM_done is issued.
//  - Address width: ADDR passes through unmodified. Max ADDR (2^ADDR_W-1) is legal;
//      there is no wrap logic here. Address wrap is the loader's responsibility.
// TESTING
//  1. Reset then idle: SRAM_CE_N/OE_N/UB_N/LB_N/WE_N = 1, DATA_OUT = 0, SRAM_done
//     never asserts for 50 cycles with reading = 0.
//  2. Single read, WAIT_CYCLES=2: ADDR=20'h4B000, SRAM model returns 16'h1234 ->
//     SRAM_ADDR = 4B000 from SETUP, SRAM_done pulses in cycle N+5, DATA_OUT = 16'h1234.
//  3. reading held high 20 cycles after DONE -> exactly one SRAM_done pulse and one
//     CE_N low window. Drop reading 1 cycle, reassert with ADDR=1 -> second read completes.
//  4. Abort: drop reading during WAIT -> IDLE next cycle, enables high, no SRAM_done,
//     DATA_OUT unchanged from the previous read.
//  5. Async Reset pulsed mid-WAIT (between edges) -> outputs reach the reset values
//     before the next edge; a new request after reset completes normally.
//  6. WAIT_CYCLES=0 build: ADDR=20'hFFFFF, data 16'hF0F0 -> SRAM_done in cycle N+3,
//     DATA_OUT = 16'hF0F0.

Source files
------------

// File: rtl/sram_read_ctrl.sv
// sram_read_ctrl
//   Read-only responder between the background loader and a 16-bit async SRAM.
//   A request (reading high in IDLE) latches ADDR onto the SRAM pins, asserts the
//   chip/output/byte enables, waits WAIT_CYCLES cycles for the SRAM access time,
//   captures SRAM_DQ into DATA_OUT and pulses SRAM_done for one cycle.
//
//   Handshake: the loader raises `reading` and keeps it high until it has seen
//   SRAM_done; dropping it before capture aborts the access without touching
//   DATA_OUT. After SRAM_done, `reading` must go low for at least one cycle
//   before the next request is accepted (a held level never re-triggers).
//
// Ports
//   Clk, Reset          clock, asynchronous active-high reset
//   reading             request level from the loader
//   ADDR                word address, sampled only on acceptance in IDLE
//   SRAM_DQ             SRAM data bus (input only here)
//   SRAM_ADDR           SRAM address pins (registered)
//   SRAM_CE_N/OE_N/UB_N/LB_N  active-low enables (registered)
//   SRAM_WE_N           write enable, tied high
//   DATA_OUT            last captured word
//   SRAM_done           one-cycle pulse when DATA_OUT holds the requested word
//   state_dbg           current FSM state encoding, for observation only

module sram_read_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              reading,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [15:0]       DATA_OUT,
  output logic              SRAM_done,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4,
    HOLD    = 3'd5
  } state_t;

  // Counter preload so that exactly WAIT_CYCLES cycles are spent in WAIT.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       en_n;  // shared register behind all four active-low enables

  assign SRAM_CE_N = en_n;
  assign SRAM_OE_N = en_n;
  assign SRAM_UB_N = en_n;
  assign SRAM_LB_N = en_n;
  assign SRAM_WE_N = 1'b1;
  assign state_dbg = state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      en_n      <= 1'b1;
      SRAM_ADDR <= '0;
      DATA_OUT  <= 16'd0;
      SRAM_done <= 1'b0;
    end else begin
      SRAM_done <= 1'b0;
      case (state)
        IDLE: begin
          if (reading) begin
            SRAM_ADDR <= ADDR;
            // Enables go low on entry so they are already low during SETUP.
            en_n      <= 1'b0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          if (!reading) begin
            en_n  <= 1'b1;
            state <= IDLE;
          end else if (WAIT_CYCLES == 0) begin
            state <= CAPTURE;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (!reading) begin
            en_n  <= 1'b1;
            state <= IDLE;
          end else if (wait_cnt == 4'd0) begin
            state <= CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        CAPTURE: begin
          // An abort here wins over the capture: DATA_OUT must keep its old word.
          if (!reading) begin
            en_n  <= 1'b1;
            state <= IDLE;
          end else begin
            DATA_OUT  <= SRAM_DQ;
            en_n      <= 1'b1;
            SRAM_done <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          state <= reading ? HOLD : IDLE;
        end

        HOLD: begin
          if (!reading) begin
            state <= IDLE;
          end
        end

        default: begin
          en_n  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
